// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART receive path: FSM state encoding and line levels.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} uart_rx_state_t;

  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_START_LVL = 1'b0;
  localparam logic UART_STOP_LVL  = 1'b1;
  localparam logic UART_IDLE_LVL  = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer for the asynchronous rx line; resets to the idle level
// so no false start bit is seen when reset is released.
module uart_rx_sync
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_96000_hz,
  input  logic reset,
  input  logic rx,
  output logic rx_s
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_96000_hz or posedge reset) begin
    if (reset) sync_q <= {SYNC_STAGES{UART_IDLE_LVL}};
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: start-bit qualification, mid-bit sampling, and a one-entry
// valid/ready holding register with framing and overrun error pulses.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk_96000_hz,
  input  logic       reset,
  input  logic       rx,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       busy
);

  localparam int CW   = $clog2(CLKS_PER_BIT + 1);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int BW   = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] BIT_RELOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'((HALF > 0) ? HALF - 1 : 0);
  localparam logic [BW-1:0] LAST_BIT    = BW'(UART_DATA_BITS - 1);

  uart_rx_state_t            state;
  logic [CW-1:0]             cnt;
  logic [BW-1:0]             bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      rx_s;
  logic                      bit_tick;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_96000_hz(clk_96000_hz),
    .reset       (reset),
    .rx          (rx),
    .rx_s        (rx_s)
  );

  assign bit_tick = (cnt == '0);

  // Data-only shifter: it is always refilled with a full byte before any commit.
  always_ff @(posedge clk_96000_hz) begin
    if (state == DATA && bit_tick) shift <= {rx_s, shift[UART_DATA_BITS-1:1]};
  end

  always_ff @(posedge clk_96000_hz or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      // Consumer handshake; a same-cycle commit below overrides this.
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (rx_s == UART_START_LVL) begin
            busy    <= 1'b1;
            bit_idx <= '0;
            if (HALF == 0) begin
              state <= DATA;
              cnt   <= BIT_RELOAD;
            end else begin
              state <= START;
              cnt   <= HALF_RELOAD;
            end
          end
        end
        START: begin
          if (!bit_tick) begin
            cnt <= cnt - 1'b1;
          end else if (rx_s == UART_START_LVL) begin
            state <= DATA;
            cnt   <= BIT_RELOAD;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        DATA: begin
          if (!bit_tick) begin
            cnt <= cnt - 1'b1;
          end else begin
            cnt     <= BIT_RELOAD;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == LAST_BIT) state <= STOP;
          end
        end
        STOP: begin
          if (!bit_tick) begin
            cnt <= cnt - 1'b1;
          end else if (rx_s == UART_STOP_LVL) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (!rx_valid || rx_ready) begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
            end else begin
              overrun_err <= 1'b1;
            end
          end else begin
            frame_err <= 1'b1;
            state     <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          // Held break: one frame_err only, then wait for the line to idle.
          if (rx_s == UART_IDLE_LVL) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: one instance at 1 clock/bit, one at 8 clocks/bit.
module tb_uart_receiver;

  logic       clk_96000_hz = 1'b0;
  logic       reset = 1'b0;
  logic       rx1 = 1'b1, rx_ready1 = 1'b0;
  logic       rx8 = 1'b1, rx_ready8 = 1'b1;
  logic [7:0] rx_data1, rx_data8;
  logic       rx_valid1, frame_err1, overrun_err1, busy1;
  logic       rx_valid8, frame_err8, overrun_err8, busy8;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_c;

  logic [7:0] got1 [0:7];
  logic [7:0] got8 [0:7];
  int n1, fe1, ov1, vcyc1, first_v1;
  int n8, fe8, ov8, vcyc8;

  always #5 clk_96000_hz = ~clk_96000_hz;
  always @(posedge clk_96000_hz) cyc <= cyc + 1;

  uart_receiver #(.CLKS_PER_BIT(1), .SYNC_STAGES(2)) dut1 (
    .clk_96000_hz(clk_96000_hz), .reset(reset), .rx(rx1), .rx_ready(rx_ready1),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .frame_err(frame_err1),
    .overrun_err(overrun_err1), .busy(busy1)
  );

  uart_receiver #(.CLKS_PER_BIT(8), .SYNC_STAGES(2)) dut8 (
    .clk_96000_hz(clk_96000_hz), .reset(reset), .rx(rx8), .rx_ready(rx_ready8),
    .rx_data(rx_data8), .rx_valid(rx_valid8), .frame_err(frame_err8),
    .overrun_err(overrun_err8), .busy(busy8)
  );

  always @(negedge clk_96000_hz) begin
    if (rx_valid1) begin
      vcyc1++;
      if (first_v1 < 0) first_v1 = cyc;
    end
    if (rx_valid1 && rx_ready1) begin
      if (n1 < 8) got1[n1] = rx_data1;
      n1++;
    end
    if (frame_err1) fe1++;
    if (overrun_err1) ov1++;
    if (rx_valid8) vcyc8++;
    if (rx_valid8 && rx_ready8) begin
      if (n8 < 8) got8[n8] = rx_data8;
      n8++;
    end
    if (frame_err8) fe8++;
    if (overrun_err8) ov8++;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_96000_hz);
      #1;
    end
  endtask

  task automatic clear_mon();
    n1 = 0; fe1 = 0; ov1 = 0; vcyc1 = 0; first_v1 = -1;
    n8 = 0; fe8 = 0; ov8 = 0; vcyc8 = 0;
    for (int i = 0; i < 8; i++) begin
      got1[i] = 8'h00;
      got8[i] = 8'h00;
    end
  endtask

  task automatic send1(input logic [7:0] b, input logic stop_bit);
    rx1 = 1'b0;
    tick(1);
    for (int i = 0; i < 8; i++) begin
      rx1 = b[i];
      tick(1);
    end
    rx1 = stop_bit;
    tick(1);
  endtask

  task automatic send8(input logic [7:0] b);
    rx8 = 1'b0;
    tick(8);
    for (int i = 0; i < 8; i++) begin
      rx8 = b[i];
      tick(8);
    end
    rx8 = 1'b1;
    tick(8);
  endtask

  initial begin
    clear_mon();
    #2 reset = 1'b1;
    tick(3);
    check_eq("rst_valid1", rx_valid1, 1'b0);
    check_eq("rst_data1",  rx_data1, 8'h00);
    check_eq("rst_busy1",  busy1, 1'b0);
    check_eq("rst_errs1",  {frame_err1, overrun_err1}, 2'b00);
    check_eq("rst_valid8", rx_valid8, 1'b0);
    check_eq("rst_busy8",  busy8, 1'b0);
    reset = 1'b0;
    tick(3);

    // T1: single byte, consumer ready
    clear_mon();
    rx_ready1 = 1'b1;
    start_c = cyc;
    send1(8'hA5, 1'b1);
    tick(6);
    check_eq("t1_count",   n1, 1);
    check_eq("t1_data",    got1[0], 8'hA5);
    check_eq("t1_vcycles", vcyc1, 1);
    check_eq("t1_latency", first_v1 - start_c, 12);
    check_eq("t1_errs",    fe1 + ov1, 0);

    // T2: back-to-back frames with consumer stalled
    clear_mon();
    rx_ready1 = 1'b0;
    send1(8'h3C, 1'b1);
    send1(8'hC3, 1'b1);
    tick(4);
    check_eq("t2_valid_held", rx_valid1, 1'b1);
    check_eq("t2_data_held",  rx_data1, 8'h3C);
    check_eq("t2_overrun",    ov1, 1);
    check_eq("t2_frame",      fe1, 0);
    rx_ready1 = 1'b1;
    tick(1);
    check_eq("t2_valid_drop", rx_valid1, 1'b0);
    check_eq("t2_data_keep",  rx_data1, 8'h3C);
    check_eq("t2_accepted",   n1, 1);
    check_eq("t2_acc_data",   got1[0], 8'h3C);

    // T3: stop bit 0 followed by a held break
    clear_mon();
    send1(8'h55, 1'b0);
    tick(20);
    check_eq("t3_busy_break", busy1, 1'b1);
    check_eq("t3_frame_once", fe1, 1);
    check_eq("t3_no_valid",   vcyc1, 0);
    rx1 = 1'b1;
    tick(4);
    check_eq("t3_busy_idle",  busy1, 1'b0);
    check_eq("t3_frame_end",  fe1, 1);
    check_eq("t3_overrun",    ov1, 0);

    // T5: reset during data bit 4 of 0xFF
    clear_mon();
    rx1 = 1'b0;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      rx1 = 1'b1;
      tick(1);
    end
    rx1 = 1'b1;
    check_eq("t5_busy_pre", busy1, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_eq("t5_async_data",  rx_data1, 8'h00);
    check_eq("t5_async_valid", rx_valid1, 1'b0);
    check_eq("t5_async_busy",  busy1, 1'b0);
    check_eq("t5_async_errs",  {frame_err1, overrun_err1}, 2'b00);
    tick(2);
    reset = 1'b0;
    tick(4);
    check_eq("t5_no_partial", n1 + fe1 + ov1, 0);
    send1(8'h12, 1'b1);
    tick(4);
    check_eq("t5_count", n1, 1);
    check_eq("t5_data",  got1[0], 8'h12);
    check_eq("t5_errs",  fe1 + ov1, 0);

    // T6: transmitter-style back-to-back 0x00, 0xFF
    clear_mon();
    send1(8'h00, 1'b1);
    send1(8'hFF, 1'b1);
    tick(6);
    check_eq("t6_count", n1, 2);
    check_eq("t6_first", got1[0], 8'h00);
    check_eq("t6_second", got1[1], 8'hFF);
    check_eq("t6_errs",  fe1 + ov1, 0);

    // T4: 8 clocks/bit, short glitch then a real frame
    clear_mon();
    rx8 = 1'b0;
    tick(3);
    rx8 = 1'b1;
    tick(20);
    check_eq("t4_glitch_busy",  busy8, 1'b0);
    check_eq("t4_glitch_valid", vcyc8, 0);
    check_eq("t4_glitch_errs",  fe8 + ov8, 0);
    send8(8'h81);
    tick(20);
    check_eq("t4_count", n8, 1);
    check_eq("t4_data",  got8[0], 8'h81);
    check_eq("t4_errs",  fe8 + ov8, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
